// File: rtl/pipe_shift_pkg.sv
// Shared types, mode encodings and level-split helper for the pipelined shifter.
package pipe_shift_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_LSR = 2'b00;
    localparam mode_t MODE_LSL = 2'b01;
    localparam mode_t MODE_ASR = 2'b10;
    localparam mode_t MODE_ROR = 2'b11;

    // First log level owned by a stage: ceil(stage*shamt_w/stages).
    // Calling it with stage+1 gives that stage's exclusive upper bound.
    function automatic int level_lo(input int stage, input int shamt_w, input int stages);
        return (stage * shamt_w + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/pipe_shift_if.sv
// Valid/ready word bus of the shifter: operand side in, result side out.
interface pipe_shift_if
    import pipe_shift_pkg::*;
#(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_in;
    mode_t              mode;
    logic [SHAMT_W-1:0] shift_amount;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_out;
    logic               sticky;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, data_in, mode, shift_amount, out_ready,
        input  in_ready, out_valid, data_out, sticky
    );

    // The shifter itself.
    modport slave (
        input  in_valid, data_in, mode, shift_amount, out_ready,
        output in_ready, out_valid, data_out, sticky
    );
endinterface

// File: rtl/pipe_shift_shift_stage.sv
// One pipeline stage of the log shifter: levels LO..HI-1 followed by a register.
module shift_stage
    import pipe_shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int LO      = 0,
    parameter int HI      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [WIDTH-1:0]   up_data,
    input  mode_t              up_mode,
    input  logic [SHAMT_W-1:0] up_shamt,
    input  logic               up_sticky,
    output logic               dn_valid,
    input  logic               dn_ready,
    output logic [WIDTH-1:0]   dn_data,
    output mode_t              dn_mode,
    output logic [SHAMT_W-1:0] dn_shamt,
    output logic               dn_sticky
);

    logic [WIDTH-1:0] data_c;
    logic             sticky_c;

    // Mask of the 2^k bits that a right shift at level k pushes off the LSB end.
    function automatic logic [WIDTH-1:0] low_mask(input int k);
        return (WIDTH'(1) << (1 << k)) - WIDTH'(1);
    endfunction

    // A stage may take a new word when it is empty or its word is leaving;
    // an empty stage always loads, so bubbles collapse.
    assign up_ready = !dn_valid || dn_ready;

    // Apply this stage's share of the log levels; sticky only gathers
    // bits lost off the right end for the non-wrapping right shifts.
    always_comb begin
        data_c   = up_data;
        sticky_c = up_sticky;
        for (int k = LO; k < HI; k++) begin
            if (up_shamt[k]) begin
                case (up_mode)
                    MODE_LSR: begin
                        sticky_c = sticky_c | (|(data_c & low_mask(k)));
                        data_c   = data_c >> (1 << k);
                    end
                    MODE_LSL: begin
                        data_c = data_c << (1 << k);
                    end
                    MODE_ASR: begin
                        // The MSB is preserved by every earlier ASR level, so it
                        // still equals the operand's sign bit here.
                        sticky_c = sticky_c | (|(data_c & low_mask(k)));
                        data_c   = WIDTH'($signed(data_c) >>> (1 << k));
                    end
                    default: begin
                        data_c = (data_c >> (1 << k)) | (data_c << (WIDTH - (1 << k)));
                    end
                endcase
            end
        end
    end

    // Occupancy flag: cleared at once by reset so in-flight words vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid <= 1'b0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
        end
    end

    // ---- stage register: word, mode, shift bits and partial sticky travel together ----
    always_ff @(posedge clk) begin
        if (up_ready && up_valid) begin
            dn_data   <= data_c;
            dn_mode   <= up_mode;
            dn_shamt  <= up_shamt;
            dn_sticky <= sticky_c;
        end
    end

endmodule

// File: rtl/pipe_shift.sv
// Pipelined logarithmic barrel shifter (LSR/LSL/ASR/ROR) with sticky output.
module pipe_shift
    import pipe_shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    pipe_shift_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               valid_s  [STAGES+1];
    logic               ready_s  [STAGES+1];
    logic [WIDTH-1:0]   data_s   [STAGES+1];
    mode_t              mode_s   [STAGES+1];
    logic [SHAMT_W-1:0] shamt_s  [STAGES+1];
    logic               sticky_s [STAGES+1];
    logic               unused_tail;

    assign valid_s[0]      = bus.in_valid;
    assign data_s[0]       = bus.data_in;
    assign mode_s[0]       = bus.mode;
    assign shamt_s[0]      = bus.shift_amount;
    assign sticky_s[0]     = 1'b0;
    assign bus.in_ready    = ready_s[0];
    assign ready_s[STAGES] = bus.out_ready;
    assign bus.out_valid   = valid_s[STAGES];

    // The result is forced to zero while no word is present, which also
    // gives zero outputs in reset without resetting the data registers.
    assign bus.data_out = valid_s[STAGES] ? data_s[STAGES] : '0;
    assign bus.sticky   = valid_s[STAGES] & sticky_s[STAGES];

    // Mode and shift bits are spent once the last level has been applied.
    assign unused_tail = ^{mode_s[STAGES], shamt_s[STAGES]};

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        shift_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .LO      (level_lo(i, SHAMT_W, STAGES)),
            .HI      (level_lo(i + 1, SHAMT_W, STAGES))
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .up_valid  (valid_s[i]),
            .up_ready  (ready_s[i]),
            .up_data   (data_s[i]),
            .up_mode   (mode_s[i]),
            .up_shamt  (shamt_s[i]),
            .up_sticky (sticky_s[i]),
            .dn_valid  (valid_s[i+1]),
            .dn_ready  (ready_s[i+1]),
            .dn_data   (data_s[i+1]),
            .dn_mode   (mode_s[i+1]),
            .dn_shamt  (shamt_s[i+1]),
            .dn_sticky (sticky_s[i+1])
        );
    end

endmodule
